if_stage: RTL
=============

// Module: if_stage
// PURPOSE
// Instruction Fetch stage: owns the fetch PC, issues word requests to instruction memory over a
// valid/ready request + in-order response interface, and buffers returned words in a small FIFO.
// Drives the IF/ID pipeline register consumed by id_stage (instruction_out, pc_curr_out).
// Handles hazard-unit stall/flush and branch/jump redirects, discarding stale in-flight responses.
// PARAMETERS
// RESET_PC   32'h0000_0000  fetch PC loaded on reset
// NOP_INSTR  32'h0000_0013  bubble word (ADDI x0,x0,0) driven when instr_valid_out=0
// BUF_DEPTH  2              max (in-flight requests + buffered words); power of 2, >=2
// PORTS
// clk                 in   1   clock, all state on rising edge
// rst                 in   1   asynchronous reset, active-high
// stall_in            in   1   hazard unit: hold IF/ID register contents
// flush_in            in   1   hazard unit: load bubble into IF/ID register
// redirect_valid_in   in   1   EX: taken branch / JAL / JALR
// redirect_pc_in      in   32  EX: redirect target (bits [1:0] ignored, forced 0)
// imem_req_valid_out  out  1   fetch request valid
// imem_req_addr_out   out  32  fetch address (word aligned)
// imem_req_ready_in   in   1   imem accepts request this cycle
// imem_resp_valid_in  in   1   response word valid (in request order, >=1 cycle after accept)
// imem_resp_data_in   in   32  response instruction word
// instr_valid_out     out  1   IF/ID holds a real instruction
// instruction_out     out  32  IF/ID instruction (NOP_INSTR when invalid)
// pc_curr_out         out  32  IF/ID PC of instruction_out (for AUIPC/branches)
// pc_plus4_out        out  32  pc_curr_out + 4 (link value), mod 2^32
// BEHAVIOUR
// - Reset (async assert): pc_q=RESET_PC, FIFO empty, in_flight=0, drop_cnt=0, instr_valid_out=0,
//   instruction_out=NOP_INSTR, pc_curr_out=RESET_PC, pc_plus4_out=RESET_PC+4; imem_req_valid_out=0
//   while rst high. Reset mid-transaction abandons everything; imem must not respond afterwards.
// - Request: imem_req_valid_out = !rst && (in_flight + fifo_count < BUF_DEPTH); addr = pc_q.
//   Valid/addr may change before acceptance (imem is a simple SRAM port, no stability rule).
//   On accept (valid&ready): in_flight++, PC tag pc_q pushed to tag queue, pc_q += 4 (wraps 2^32).
// - Response: pops oldest tag; if drop_cnt>0 -> discard, drop_cnt--; else push {tag,data} to FIFO.
//   Response with in_flight==0 is a protocol error (assertion only).
// - IF/ID update each edge, priority rst > redirect > flush > stall > advance:
//   redirect or flush: instr_valid_out=0, instruction_out=NOP_INSTR (PC outputs hold).
//   stall: all IF/ID outputs hold; FIFO keeps filling up to BUF_DEPTH.
//   advance: FIFO non-empty -> pop head into IF/ID, valid=1; FIFO empty but non-dropped response
//   this cycle -> bypass it directly into IF/ID (FIFO untouched); else bubble.
// - Latency: request accepted cycle N, response cycle R>=N+1, instr_valid_out=1 from R+1 when
//   FIFO empty and not stalled. Sustains 1 instr/cycle with 1-cycle imem and BUF_DEPTH>=2.
// - Redirect (cycle C): pc_q<=redirect_pc_in, FIFO cleared, drop_cnt<=in_flight (+1 if request
//   accepted in C, -1 if response arrives in C, net applied once); no request issued in C is
//   valid for the new path. Redirect overrides stall. First new-path request issued in C+1.
// - Flush without redirect: only IF/ID bubbled; FIFO and PC untouched.
// - Simultaneous push+pop on FIFO allowed at full or empty; count unchanged.
// TESTING
// - Reset, 1-cycle imem always ready, words 0x00100093.. -> PCs 0x0,0x4,0x8 on consecutive cycles, valid from cycle 2.
// - stall_in high 3 cycles during streaming -> IF/ID frozen, req_valid drops once count=BUF_DEPTH, no word lost/duplicated after release.
// - Redirect to 0x100 with 2 requests in flight (3-cycle imem) -> both responses dropped, next valid instr pc_curr_out=0x100.
// - Redirect and stall same cycle -> IF/ID bubbled (NOP 0x00000013, valid=0), fetch restarts at target.
// - flush_in single cycle -> one bubble, next cycle resumes with the un-lost following instruction in order.
// - rst asserted mid-fetch at PC 0x40 -> outputs reset asynchronously, fetch restarts at RESET_PC; pc 0xFFFFFFFC+4 wraps to 0x0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage.
// Owns the fetch PC and issues word requests to instruction memory.
// Requests use valid/ready; responses come back in order. Returned words are
// buffered in a small FIFO, and the stage drives the IF/ID pipeline register.
// A redirect clears the buffered path and counts off the responses still in
// flight, so stale words are discarded as they arrive.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_valid_out,
  output logic [31:0] imem_req_addr_out,
  input  logic        imem_req_ready_in,
  input  logic        imem_resp_valid_in,
  input  logic [31:0] imem_resp_data_in,
  output logic        instr_valid_out,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_curr_out,
  output logic [31:0] pc_plus4_out
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(BUF_DEPTH);
  localparam logic [CW:0]   DEPTH_OCC = (CW+1)'(BUF_DEPTH);

  // fetch PC
  logic [31:0]   pc_q;

  // PC tags of accepted-but-unanswered requests, oldest at tag_rd_ptr
  logic [31:0]   tag_mem [BUF_DEPTH];
  logic [PW-1:0] tag_wr_ptr;
  logic [PW-1:0] tag_rd_ptr;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] drop_cnt;

  // returned words waiting for the IF/ID register
  logic [31:0]   fifo_pc   [BUF_DEPTH];
  logic [31:0]   fifo_data [BUF_DEPTH];
  logic [PW-1:0] fifo_wr_ptr;
  logic [PW-1:0] fifo_rd_ptr;
  logic [CW-1:0] fifo_count;

  // IF/ID register
  logic          instr_valid_q;
  logic [31:0]   instruction_q;
  logic [31:0]   pc_curr_q;

  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          resp_fire;
  logic          resp_drop;
  logic          resp_keep;
  logic [31:0]   resp_tag;
  logic          fifo_empty;
  logic          advance;
  logic          fifo_pop;
  logic          fifo_push;
  logic          bypass;
  logic [CW-1:0] in_flight_nxt;
  logic [31:0]   redirect_target;

  // A request is only offered while there is guaranteed room for its
  // response.
  assign occupancy          = {1'b0, in_flight} + {1'b0, fifo_count};
  assign imem_req_valid_out = !rst && (occupancy < DEPTH_OCC);
  assign imem_req_addr_out  = pc_q;

  assign req_fire      = imem_req_valid_out && imem_req_ready_in;
  assign resp_fire     = imem_resp_valid_in;
  assign resp_drop     = resp_fire && (drop_cnt != '0);
  assign resp_keep     = resp_fire && !resp_drop;
  assign resp_tag      = tag_mem[tag_rd_ptr];
  assign in_flight_nxt = in_flight + CW'(req_fire) - CW'(resp_fire);

  assign fifo_empty = (fifo_count == '0);
  assign advance    = !redirect_valid_in && !flush_in && !stall_in;
  assign fifo_pop   = advance && !fifo_empty;
  // An empty FIFO lets a fresh response go straight into IF/ID. This
  // gives 1 instr/cycle with a 1-cycle imem.
  assign bypass     = advance && fifo_empty && resp_keep;
  // A redirect discards whatever arrives in the same cycle.
  assign fifo_push  = resp_keep && !redirect_valid_in && !bypass;

  assign redirect_target = redirect_pc_in & 32'hFFFF_FFFC;

  // fetch PC: redirect wins over the sequential increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid_in) begin
      pc_q <= redirect_target;
    end else if (req_fire) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // tag queue pointers, outstanding count and stale-response counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      in_flight  <= '0;
      drop_cnt   <= '0;
    end else begin
      if (req_fire) begin
        tag_wr_ptr <= tag_wr_ptr + PW'(1);
      end
      if (resp_fire) begin
        tag_rd_ptr <= tag_rd_ptr + PW'(1);
      end
      in_flight <= in_flight_nxt;
      // After a redirect, every request still unanswered belongs to the
      // old path. This includes one accepted in the redirect cycle itself.
      if (redirect_valid_in) begin
        drop_cnt <= in_flight_nxt;
      end else if (resp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // tag storage, written on accept
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr_ptr] <= pc_q;
    end
  end

  // FIFO pointers and count; a redirect empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
    end else if (redirect_valid_in) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
    end else begin
      if (fifo_push) begin
        fifo_wr_ptr <= fifo_wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        fifo_rd_ptr <= fifo_rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // FIFO storage of {pc, instruction}
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_pc[fifo_wr_ptr]   <= resp_tag;
      fifo_data[fifo_wr_ptr] <= imem_resp_data_in;
    end
  end

  // IF/ID register: redirect > flush > stall > advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid_q <= 1'b0;
      instruction_q <= NOP_INSTR;
      pc_curr_q     <= RESET_PC;
    end else if (redirect_valid_in || flush_in) begin
      instr_valid_q <= 1'b0;
      instruction_q <= NOP_INSTR;
    end else if (!stall_in) begin
      if (!fifo_empty) begin
        instr_valid_q <= 1'b1;
        instruction_q <= fifo_data[fifo_rd_ptr];
        pc_curr_q     <= fifo_pc[fifo_rd_ptr];
      end else if (bypass) begin
        instr_valid_q <= 1'b1;
        instruction_q <= imem_resp_data_in;
        pc_curr_q     <= resp_tag;
      end else begin
        instr_valid_q <= 1'b0;
        instruction_q <= NOP_INSTR;
      end
    end
  end

  assign instr_valid_out = instr_valid_q;
  assign instruction_out = instruction_q;
  assign pc_curr_out     = pc_curr_q;
  assign pc_plus4_out    = pc_curr_q + 32'd4;

  // imem must never answer when nothing is outstanding
  resp_without_req: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid_in |-> (in_flight != '0));

  // the request throttle keeps the FIFO from ever overflowing
  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && !fifo_pop && (fifo_count == DEPTH_CNT)));

endmodule
